// File: rtl/mux_stream_arb_prm.sv
// N-channel streaming multiplexer with internal arbitration.
// Every input channel is a valid/ready stream carrying a packet-end flag. An
// arbiter picks one channel (fixed priority or round-robin, chosen at run time)
// and holds that choice until the packet ends. The chosen beat is registered
// onto a single output stream, and sel_o reports which channel it came from.
//
// Handshake: a beat moves across an interface at a rising edge where valid and
// ready are both high. A producer holds valid (and data/last) steady until that
// edge. Ready may depend combinationally on valid, but valid never depends on
// ready. vld_o is driven only from a register.
module mux_stream_arb_prm #(
  parameter int  CH_NUM    = 4,
  parameter int  DAT_WIDTH = 8,
  localparam int SEL_WIDTH = $clog2(CH_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rr_en,
  input  logic [CH_NUM-1:0]                 vld_i,
  output logic [CH_NUM-1:0]                 rdy_i,
  input  logic [CH_NUM-1:0]                 last_i,
  input  logic [CH_NUM-1:0][DAT_WIDTH-1:0]  dat_i,
  output logic                              vld_o,
  input  logic                              rdy_o,
  output logic                              last_o,
  output logic [DAT_WIDTH-1:0]              dat_o,
  output logic [SEL_WIDTH-1:0]              sel_o,
  output logic                              dbg_state
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_WIDTH-1:0]  g;
  logic                  any_req;
  logic                  load;
  logic                  xfer;
  logic [SEL_WIDTH-1:0]  g_next;

  // The output register can take a new beat when it is empty or being drained.
  assign load = !vld_o || rdy_o;
  assign xfer = load && any_req;

  // A high dbg_state means the arbiter is locked onto a channel.
  assign dbg_state = (state_q == LOCK);

  // The channel after g, wrapping from CH_NUM-1 back to 0. This also works
  // when CH_NUM is not a power of two.
  assign g_next = (g == SEL_WIDTH'(CH_NUM - 1)) ? '0 : g + SEL_WIDTH'(1);

  // Pick the candidate channel g. While locked, only the locked channel may
  // win. Otherwise, use a round-robin search from ptr or the lowest valid index.
  always_comb begin
    g       = '0;
    any_req = 1'b0;
    if (state_q == LOCK) begin
      g       = lock_ch_q;
      any_req = vld_i[lock_ch_q];
    end else if (rr_en) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!any_req && vld_i[(int'(ptr_q) + i) % CH_NUM]) begin
          g       = SEL_WIDTH'((int'(ptr_q) + i) % CH_NUM);
          any_req = 1'b1;
        end
      end
    end else begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (vld_i[i]) begin
          g       = SEL_WIDTH'(i);
          any_req = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted channel. It is forced low while reset is
  // asserted, because the registers alone would leave load high during reset.
  always_comb begin
    rdy_i = '0;
    if (rst_n && xfer) begin
      rdy_i[g] = 1'b1;
    end
  end

  // Next-state logic. A non-final beat locks onto its channel. A final beat
  // returns to IDLE and moves the round-robin pointer past that channel.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (last_i[g]) begin
        state_d = IDLE;
        ptr_d   = g_next;
      end else begin
        state_d   = LOCK;
        lock_ch_d = g;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Registered output stage. It holds while stalled, replaces the beat on
  // drain and accept, and empties when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o  <= 1'b0;
      last_o <= 1'b0;
      dat_o  <= '0;
      sel_o  <= '0;
    end else if (load) begin
      vld_o <= xfer;
      if (xfer) begin
        last_o <= last_i[g];
        dat_o  <= dat_i[g];
        sel_o  <= g;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_arb_prm.sv
// Bench for mux_stream_arb_prm: a 4-channel instance driven through a scoreboard,
// plus a 3-channel instance for the non-power-of-two round-robin wrap.
module tb_mux_stream_arb_prm;

  localparam int SW = 2;
  localparam int EW = SW + 1 + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rr_en = 1'b0;
  logic [3:0]       vld_i = '0;
  logic [3:0]       last_i = '0;
  logic [3:0][7:0]  dat_i = '0;
  logic [3:0]       rdy_i;
  logic             vld_o;
  logic             rdy_o = 1'b1;
  logic             last_o;
  logic [7:0]       dat_o;
  logic [SW-1:0]    sel_o;
  logic             dbg_state;

  logic [2:0]       vld_i3 = '0;
  logic [2:0]       last_i3 = '0;
  logic [2:0][7:0]  dat_i3 = '0;
  logic [2:0]       rdy_i3;
  logic             vld_o3;
  logic             last_o3;
  logic [7:0]       dat_o3;
  logic [1:0]       sel_o3;
  logic             dbg_state3;

  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    exp_e;
  int               n_cmp = 0;
  int               n_err = 0;

  mux_stream_arb_prm #(.CH_NUM(4), .DAT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
    .vld_i(vld_i), .rdy_i(rdy_i), .last_i(last_i), .dat_i(dat_i),
    .vld_o(vld_o), .rdy_o(rdy_o), .last_o(last_o), .dat_o(dat_o),
    .sel_o(sel_o), .dbg_state(dbg_state)
  );

  mux_stream_arb_prm #(.CH_NUM(3), .DAT_WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
    .vld_i(vld_i3), .rdy_i(rdy_i3), .last_i(last_i3), .dat_i(dat_i3),
    .vld_o(vld_o3), .rdy_o(1'b1), .last_o(last_o3), .dat_o(dat_o3),
    .sel_o(sel_o3), .dbg_state(dbg_state3)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Scoreboard monitor: each output beat accepted downstream is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && vld_o && rdy_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mon_unexpected: got sel=%0d last=%0b dat=%h, required no beat", sel_o, last_o, dat_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({sel_o, last_o, dat_o} !== exp_e) begin
          n_err++;
          $display("FAIL mon_beat: got sel=%0d last=%0b dat=%h, required sel=%0d last=%0b dat=%h",
                   sel_o, last_o, dat_o, exp_e[EW-1 -: SW], exp_e[8], exp_e[7:0]);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input int ch, input logic l, input logic [7:0] d);
    exp_q.push_back({SW'(ch), l, d});
  endfunction

  // Wait for the scoreboard to empty within a bounded number of cycles.
  task automatic drain();
    int t;
    t = 0;
    rdy_o = 1'b1;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0;
    vld_i = '0; last_i = '0; vld_i3 = '0; last_i3 = '0; rdy_o = 1'b1;
    repeat (2) step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vld_i = 4'hF; vld_i3 = 3'b111;
    @(negedge clk);
    n_cmp++;
    if ({vld_o, last_o, dat_o, sel_o} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got vld=%0b last=%0b dat=%h sel=%0d, required all 0", vld_o, last_o, dat_o, sel_o);
    end
    n_cmp++;
    if (rdy_i !== 4'b0000 || rdy_i3 !== 3'b000) begin
      n_err++;
      $display("FAIL reset_rdy: got rdy_i=%b rdy_i3=%b, required 0000/000", rdy_i, rdy_i3);
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %0b, required 0", dbg_state);
    end
    step();
    vld_i = '0; vld_i3 = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_beat();
    rr_en = 1'b0; rdy_o = 1'b1;
    vld_i = 4'b0100; last_i = 4'b0100; dat_i[2] = 8'hC2;
    push_exp(2, 1'b1, 8'hC2);
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0100) begin
      n_err++;
      $display("FAIL single_rdy: got %b, required 0100", rdy_i);
    end
    step();
    vld_i = '0; last_i = '0;
    @(negedge clk);
    n_cmp++;
    if ({vld_o, dat_o, sel_o, last_o} !== {1'b1, 8'hC2, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL single_out: got vld=%0b dat=%h sel=%0d last=%0b, required 1/c2/2/1", vld_o, dat_o, sel_o, last_o);
    end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    rr_en = 1'b0; rdy_o = 1'b1;
    vld_i = 4'b0010; last_i = 4'b0000; dat_i[1] = 8'h77;
    step();
    n_cmp++;
    if (vld_o !== 1'b1 || dbg_state !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got vld=%0b state=%0b, required 1/1", vld_o, dbg_state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vld_o, last_o, dat_o, sel_o} !== '0 || rdy_i !== 4'b0000 || dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: got vld=%0b last=%0b dat=%h sel=%0d rdy=%b st=%0b, required all 0",
               vld_o, last_o, dat_o, sel_o, rdy_i, dbg_state);
    end
    step();
    vld_i = '0;
    exp_q.delete();
    rst_n = 1'b1;
    vld_i = 4'b1000; last_i = 4'b1000; dat_i[3] = 8'hD3;
    push_exp(3, 1'b1, 8'hD3);
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_after: got rdy_i=%b, required 1000", rdy_i);
    end
    step();
    vld_i = '0; last_i = '0;
    drain();
  endtask

  task automatic test_round_robin();
    apply_reset();
    rr_en = 1'b1; rdy_o = 1'b1;
    vld_i = 4'hF; last_i = 4'hF;
    for (int c = 0; c < 4; c++) dat_i[c] = 8'h10 + 8'(c);
    vld_i3 = 3'b111; last_i3 = 3'b111;
    for (int c = 0; c < 3; c++) dat_i3[c] = 8'h20 + 8'(c);
    for (int i = 0; i < 6; i++) push_exp(i % 4, 1'b1, 8'h10 + 8'(i % 4));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy_i !== 4'(1 << (i % 4))) begin
        n_err++;
        $display("FAIL rr4_rdy[%0d]: got %b, required %b", i, rdy_i, 4'(1 << (i % 4)));
      end
      if (i < 4) begin
        n_cmp++;
        if (rdy_i3 !== 3'(1 << (i % 3))) begin
          n_err++;
          $display("FAIL rr3_rdy[%0d]: got %b, required %b", i, rdy_i3, 3'(1 << (i % 3)));
        end
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if ({vld_o3, sel_o3, dat_o3} !== {1'b1, 2'((i - 1) % 3), 8'h20 + 8'((i - 1) % 3)}) begin
          n_err++;
          $display("FAIL rr3_out[%0d]: got vld=%0b sel=%0d dat=%h, required 1/%0d/%h",
                   i, vld_o3, sel_o3, dat_o3, (i - 1) % 3, 8'h20 + 8'((i - 1) % 3));
        end
      end
      step();
      if (i == 3) begin
        vld_i3 = '0; last_i3 = '0;
      end
    end
    vld_i = '0; last_i = '0;
    drain();
  endtask

  task automatic test_fixed_lock();
    rr_en = 1'b0; rdy_o = 1'b1;
    vld_i = 4'b0010; last_i = 4'b0000; dat_i[1] = 8'h11;
    push_exp(1, 1'b0, 8'h11); push_exp(1, 1'b0, 8'h12);
    push_exp(1, 1'b1, 8'h13); push_exp(0, 1'b1, 8'h05);
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0010) begin
      n_err++;
      $display("FAIL lock_rdy0: got %b, required 0010", rdy_i);
    end
    step();
    dat_i[1] = 8'h12; vld_i = 4'b0011; last_i = 4'b0001; dat_i[0] = 8'h05;
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0010 || dbg_state !== 1'b1) begin
      n_err++;
      $display("FAIL lock_rdy1: got rdy=%b state=%0b, required 0010/1", rdy_i, dbg_state);
    end
    step();
    dat_i[1] = 8'h13; last_i = 4'b0011; rr_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0010) begin
      n_err++;
      $display("FAIL lock_rdy2: got %b, required 0010", rdy_i);
    end
    step();
    vld_i = 4'b0001; last_i = 4'b0001; rr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0001) begin
      n_err++;
      $display("FAIL lock_rdy3: got %b, required 0001", rdy_i);
    end
    step();
    vld_i = '0; last_i = '0;
    drain();
  endtask

  task automatic test_backpressure();
    rr_en = 1'b0; rdy_o = 1'b1;
    vld_i = 4'b0100; last_i = 4'b0000; dat_i[2] = 8'hA5;
    push_exp(2, 1'b0, 8'hA5); push_exp(2, 1'b0, 8'hA6); push_exp(2, 1'b1, 8'hA7);
    step();
    rdy_o = 1'b0; dat_i[2] = 8'hA6;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({vld_o, dat_o, sel_o, last_o} !== {1'b1, 8'hA5, 2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold: got vld=%0b dat=%h sel=%0d last=%0b, required 1/a5/2/0", vld_o, dat_o, sel_o, last_o);
      end
      n_cmp++;
      if (rdy_i !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_rdy: got %b, required 0000", rdy_i);
      end
      step();
    end
    rdy_o = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy_i !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_resume: got %b, required 0100", rdy_i);
    end
    step();
    dat_i[2] = 8'hA7; last_i = 4'b0100;
    step();
    vld_i = '0; last_i = '0;
    drain();
  endtask

  task automatic test_lock_gaps();
    for (int m = 1; m >= 0; m--) begin
      rr_en = m[0]; rdy_o = 1'b1;
      vld_i = 4'b1000; last_i = 4'b0000; dat_i[3] = 8'h3A;
      push_exp(3, 1'b0, 8'h3A); push_exp(3, 1'b1, 8'h3B); push_exp(0, 1'b1, 8'h0A);
      @(negedge clk);
      n_cmp++;
      if (rdy_i !== 4'b1000) begin
        n_err++;
        $display("FAIL gap_first[m=%0d]: got %b, required 1000", m, rdy_i);
      end
      step();
      vld_i = 4'b0001; last_i = 4'b0001; dat_i[0] = 8'h0A;
      repeat (2) begin
        @(negedge clk);
        n_cmp++;
        if (rdy_i !== 4'b0000 || dbg_state !== 1'b1) begin
          n_err++;
          $display("FAIL gap_hold[m=%0d]: got rdy=%b state=%0b, required 0000/1", m, rdy_i, dbg_state);
        end
        step();
      end
      vld_i = 4'b1001; last_i = 4'b1001; dat_i[3] = 8'h3B;
      @(negedge clk);
      n_cmp++;
      if (rdy_i !== 4'b1000) begin
        n_err++;
        $display("FAIL gap_last[m=%0d]: got %b, required 1000", m, rdy_i);
      end
      step();
      vld_i = 4'b0001;
      @(negedge clk);
      n_cmp++;
      if (rdy_i !== 4'b0001) begin
        n_err++;
        $display("FAIL gap_next[m=%0d]: got %b, required 0001", m, rdy_i);
      end
      step();
      vld_i = '0; last_i = '0;
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int len;
    int guard;
    logic got;
    logic [7:0] d;
    for (int pkt = 0; pkt < 8; pkt++) begin
      int ch;
      ch = pkt % 4;
      rr_en = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom_range(0, 255));
        push_exp(ch, (b == len - 1), d);
        dat_i[ch] = d;
        last_i = '0;
        last_i[ch] = (b == len - 1);
        guard = 0;
        got = 1'b0;
        while (!got && guard < 100) begin
          vld_i = '0;
          vld_i[ch] = ($urandom_range(0, 3) != 0);
          rdy_o = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          got = rdy_i[ch] && vld_i[ch];
          step();
          guard++;
        end
        if (!got) begin
          n_cmp++;
          n_err++;
          $display("FAIL b2b_grant: ch%0d beat %0d not granted in 100 cycles, required grant", ch, b);
        end
      end
      vld_i = '0; last_i = '0;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_reset_mid_packet();
    test_round_robin();
    test_fixed_lock();
    test_backpressure();
    test_lock_gaps();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
